bcd_updown_counter: RTL and testbench
=====================================

Name: bcd_updown_counter

Overview:
- 4-digit packed-BCD up/down counter that produces the 16-bit value driven into the 4-digit 7-segment display driver's `in` port.
- Advances on a programmable prescaler tick or on a debounced manual step button.
- Supports synchronous parallel load and emits a one-cycle carry/borrow pulse on wrap.
- Sits directly upstream of the display driver in the Lab 2 counter design.

Parameters:
- PRESCALE, 100000000: clk cycles per automatic count tick (≥2).
- DEBOUNCE, 1000000: clk cycles step_btn must be stable before its new level is accepted (≥2).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  enables prescaler ticks; does not gate manual steps or load.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled at the advance event.
- step_btn  input  1  raw asynchronous push-button; each accepted press is one count step.
- load  input  1  synchronous load strobe.
- load_val  input  16  packed BCD load value: [15:12] thousands … [3:0] units.
- count  output  16  registered packed BCD count; connects to the display driver `in`.
- carry  output  1  one-cycle pulse on wrap (9999→0000 up, 0000→9999 down).

Behaviour:
- Reset: rst=1 asynchronously forces the following, and holds them while asserted:
  - count=16'h0000, carry=0;
  - prescaler=0;
  - synchronizer FFs=0, debounce counter=0, debounced level=0, edge-detect register=0.
- Prescaler:
  - Counts 0..PRESCALE-1 while en=1 and holds its value while en=0.
  - tick=1 for exactly one cycle when the prescaler is at PRESCALE-1 and en=1; the prescaler then returns to 0.
- Step path:
  - 2-FF synchronizer on step_btn.
  - Debounce: when the synchronized level differs from the debounced level, a counter increments; when it equals the debounced level, the counter clears.
  - When the counter reaches DEBOUNCE-1, the debounced level takes the new value and the counter clears.
  - step pulse = one cycle on the rising edge of the debounced level; release generates nothing.
- Advance event: adv = tick | step. Coincident tick and step advance the count by one, not two.
- Priority per cycle: load > adv > hold.
- Load:
  - count <= load_val, with any digit >9 clamped to 9 (e.g. 16'h3AF2 → 16'h3992).
  - Prescaler clears to 0.
  - carry=0 that cycle.
  - A coincident adv is discarded.
- Increment: units+1; any digit at 9 becomes 0 and carries into the next digit. 9999 → 0000 with carry=1 next cycle.
- Decrement: units-1; any digit at 0 becomes 9 and borrows from the next digit. 0000 → 9999 with carry=1 next cycle.
- Latency: count and carry update on the clock edge after the cycle in which adv/load is seen (one-cycle registered latency).
- carry is 0 in every cycle that has no wrap.
- count never holds a non-BCD digit.
- Mid-operation reset aborts any pending debounce or prescale progress; no step is generated by a button already held at reset release until the debounced level rises from 0 after the full DEBOUNCE interval.
- Changing `up` between events has effect only at the next event.

Test Plan:
- PRESCALE=4, DEBOUNCE=3, rst pulse mid-run, en=1, up=1:
  - count=0000 during rst.
  - Then 0001, 0002, 0003 every 4 clocks.
  - Mid-run rst returns the counter to 0000 asynchronously, without waiting for a clock edge.
- load_val=16'h9998, load=1 one cycle, then en=1, up=1:
  - count=9998 → 9999 → 0000.
  - carry=1 for exactly one cycle, aligned with 0000.
  - Next value 0001 with carry=0.
- load_val=16'h0001, up=0, en=1:
  - count=0001 → 0000 → 9999 with carry pulse.
  - Then 9998.
  - Also load 16'h3AF2 → count=3992.
- en=0, step_btn bounced (0/1 toggles every cycle for 6 cycles), then held 1 for ≥5 cycles, then released:
  - Exactly one increment, 0000 → 0001.
  - No change on release.
  - Prescaler frozen throughout.
- Coincidences:
  - tick and step in the same cycle → single increment.
  - load and tick in the same cycle → count=load_val, with the prescaler restarting from 0 (next tick 4 cycles later).
- Digit ripple, up=1: load 0099 → 0100; load 0999 → 1000; load 0909 → 0910.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: 4-digit packed-BCD up/down counter advanced by a prescaler tick or a debounced step button,
// with clamped parallel load and a one-cycle wrap pulse on carry.
module bcd_updown_counter #(
    parameter int PRESCALE = 100000000,
    parameter int DEBOUNCE = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        up,
    input  logic        step_btn,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] count,
    output logic        carry
);
    localparam int PW = $clog2(PRESCALE);
    localparam int DW = $clog2(DEBOUNCE);

    logic [PW-1:0] pre;
    logic [DW-1:0] dc;
    logic          s1, s2, db, db_q;
    logic          tick, step, adv, wrap;

    function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic inc);
        logic [15:0] r;
        logic        c;
        logic [3:0]  d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                r[4*i +: 4] = inc ? (d == 4'd9 ? 4'd0 : d + 4'd1) : (d == 4'd0 ? 4'd9 : d - 4'd1);
                c = inc ? d == 4'd9 : d == 4'd0;
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] clamp(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = v[4*i +: 4] > 4'd9 ? 4'd9 : v[4*i +: 4];
        return r;
    endfunction

    assign tick = en && pre == PW'(PRESCALE - 1);
    assign step = db & ~db_q;
    assign adv  = tick | step;
    assign wrap = up ? count == 16'h9999 : count == 16'h0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pre <= '0;
        else if (load || tick) pre <= '0;
        else if (en) pre <= pre + 1'b1;
    end

    // the debounced level only moves after DEBOUNCE consecutive cycles of disagreement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            db   <= 1'b0;
            db_q <= 1'b0;
            dc   <= '0;
        end else begin
            s1   <= step_btn;
            s2   <= s1;
            db_q <= db;
            if (s2 == db) dc <= '0;
            else if (dc == DW'(DEBOUNCE - 1)) begin
                db <= s2;
                dc <= '0;
            end else dc <= dc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 16'h0000;
            carry <= 1'b0;
        end else begin
            carry <= !load && adv && wrap;
            if (load) count <= clamp(load_val);
            else if (adv) count <= bcd_step(count, up);
        end
    end
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: directed test of the BCD counter with PRESCALE=4, DEBOUNCE=3.
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
module tb_bcd_updown_counter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        step_btn = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic [15:0] count;
    logic        carry;
    int          errors = 0;
    int          checks = 0;

    bcd_updown_counter #(.PRESCALE(4), .DEBOUNCE(3)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .step_btn(step_btn),
        .load(load), .load_val(load_val), .count(count), .carry(carry)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load_val = v;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    // after a load the prescaler is 0, so exactly four enabled cycles give one tick
    task automatic tick_once();
        en = 1'b1;
        cyc(4);
        en = 1'b0;
    endtask

    initial begin
        cyc(3);
        chk("reset count", count, 16'h0000);
        chk("reset carry", {15'd0, carry}, 16'h0000);
        rst = 1'b0;
        en = 1'b1;
        up = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc(3);
            chk("auto hold", count, 16'(k - 1));
            cyc();
            chk("auto step", count, 16'(k));
        end
        cyc(2);
        #3 rst = 1'b1;
        #1 chk("async reset", count, 16'h0000);
        cyc();
        rst = 1'b0;
        en = 1'b0;

        do_load(16'h9998);
        chk("load 9998", count, 16'h9998);
        en = 1'b1;
        cyc(4);
        chk("up 9999", count, 16'h9999);
        chk("no carry 9999", {15'd0, carry}, 16'h0000);
        cyc(4);
        chk("wrap up 0000", count, 16'h0000);
        chk("carry up", {15'd0, carry}, 16'h0001);
        cyc();
        chk("carry one cycle", {15'd0, carry}, 16'h0000);
        cyc(3);
        chk("after wrap 0001", count, 16'h0001);
        chk("carry after", {15'd0, carry}, 16'h0000);
        en = 1'b0;

        up = 1'b0;
        do_load(16'h0001);
        en = 1'b1;
        cyc(4);
        chk("down 0000", count, 16'h0000);
        chk("no borrow 0000", {15'd0, carry}, 16'h0000);
        cyc(4);
        chk("wrap down 9999", count, 16'h9999);
        chk("borrow", {15'd0, carry}, 16'h0001);
        cyc();
        chk("borrow one cycle", {15'd0, carry}, 16'h0000);
        cyc(3);
        chk("down 9998", count, 16'h9998);
        en = 1'b0;
        do_load(16'h3AF2);
        chk("clamp 3AF2", count, 16'h3992);
        do_load(16'hFFFF);
        chk("clamp FFFF", count, 16'h9999);

        up = 1'b1;
        do_load(16'h0000);
        for (int i = 0; i < 6; i++) begin
            step_btn = ~step_btn;
            cyc();
        end
        step_btn = 1'b0;
        cyc(4);
        chk("bounce ignored", count, 16'h0000);
        step_btn = 1'b1;
        cyc(10);
        chk("single step", count, 16'h0001);
        step_btn = 1'b0;
        cyc(10);
        chk("release no step", count, 16'h0001);
        en = 1'b1;
        cyc(3);
        chk("prescaler frozen", count, 16'h0001);
        cyc();
        chk("tick after freeze", count, 16'h0002);
        en = 1'b0;

        // press lands as step in the cycle after edge 5; enabling after edge 2 puts a tick there too
        do_load(16'h0000);
        step_btn = 1'b1;
        cyc(2);
        en = 1'b1;
        cyc(3);
        chk("coincide before", count, 16'h0000);
        cyc();
        chk("coincide single", count, 16'h0001);
        cyc(3);
        chk("coincide hold", count, 16'h0001);
        cyc();
        chk("next tick", count, 16'h0002);
        step_btn = 1'b0;
        cyc(3);
        load_val = 16'h1234;
        load = 1'b1;
        cyc();
        load = 1'b0;
        chk("load over tick", count, 16'h1234);
        chk("load carry", {15'd0, carry}, 16'h0000);
        cyc(3);
        chk("restart hold", count, 16'h1234);
        cyc();
        chk("restart tick", count, 16'h1235);
        en = 1'b0;

        do_load(16'h0099);
        tick_once();
        chk("ripple 0100", count, 16'h0100);
        do_load(16'h0999);
        tick_once();
        chk("ripple 1000", count, 16'h1000);
        do_load(16'h0909);
        tick_once();
        chk("ripple 0910", count, 16'h0910);
        up = 1'b0;
        do_load(16'h1000);
        tick_once();
        chk("borrow 0999", count, 16'h0999);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
